// File: rtl/samp_pool2x2.sv
`default_nettype none
// ============================================================================
//  Module   : samp_pool2x2
//  Brief    : 2x2 / stride-2 max or average pooling over a raster pixel
//             stream. One pooled pixel is produced per completed window.
//  Revision : 1.0  initial release
// ============================================================================
module samp_pool2x2 #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic              h_clk,
  input  logic              h_resetn,
  input  logic              Input_Reset,
  input  logic [DATA_W-1:0] Input_Pixel,
  input  logic              Input_Valid,
  input  logic              Input_Finish,
  input  logic              Pool_Mode,
  output logic [DATA_W-1:0] Output_Pixel,
  output logic              Output_Valid,
  output logic              Output_Finish,
  output logic              Frame_Error
);

  localparam int LB_DEPTH = IMG_W / 2;
  localparam int LBW      = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam int CW       = LBW + 1;
  localparam int RW       = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TOP  = 2'd1,
    S_BOT  = 2'd2
  } state_t;

  state_t                   state;
  logic [CW-1:0]            col;
  logic [RW-1:0]            row;
  logic                     mode_q;
  logic signed [DATA_W-1:0] hold_q;
  // Horizontal partials of the top row; one extra bit keeps the pair sum exact.
  logic signed [DATA_W:0]   lbuf [LB_DEPTH];

  logic signed [DATA_W-1:0] pix;
  logic [LBW-1:0]           lb_idx;
  logic signed [DATA_W:0]   hold_ext, pix_ext, h_sum, h_max, horiz, lb_rd;
  logic signed [DATA_W+1:0] lb_ext, horiz_ext, v_sum, v_shr;
  logic signed [DATA_W:0]   v_max;
  logic [DATA_W-1:0]        result;
  logic                     last_col, last_px, win_done;

  assign pix       = Input_Pixel;
  assign lb_idx    = col[CW-1:1];
  assign hold_ext  = {hold_q[DATA_W-1], hold_q};
  assign pix_ext   = {pix[DATA_W-1], pix};
  assign h_sum     = hold_ext + pix_ext;
  assign h_max     = (hold_q > pix) ? hold_ext : pix_ext;
  assign horiz     = mode_q ? h_sum : h_max;
  assign lb_rd     = lbuf[lb_idx];
  assign lb_ext    = {lb_rd[DATA_W], lb_rd};
  assign horiz_ext = {horiz[DATA_W], horiz};
  assign v_sum     = lb_ext + horiz_ext;
  // Arithmetic shift floors toward minus infinity; the quotient of four
  // DATA_W values always fits back into DATA_W bits.
  assign v_shr     = v_sum >>> 2;
  assign v_max     = (lb_rd > horiz) ? lb_rd : horiz;
  assign result    = mode_q ? v_shr[DATA_W-1:0] : v_max[DATA_W-1:0];

  assign last_col  = (col == COL_LAST);
  assign last_px   = last_col && (row == ROW_LAST);
  assign win_done  = Input_Valid && (state == S_BOT) && col[0];

  // Datapath storage: even-column pixel holder and top-row partial buffer.
  always_ff @(posedge h_clk) begin
    if (Input_Valid && !col[0]) hold_q <= pix;
    if (Input_Valid && (state == S_TOP) && col[0]) lbuf[lb_idx] <= horiz;
  end

  // Frame FSM: position counters, mode latch and registered output pulses.
  always_ff @(posedge h_clk) begin
    if (!h_resetn || Input_Reset) begin
      state         <= S_IDLE;
      col           <= '0;
      row           <= '0;
      mode_q        <= 1'b0;
      Output_Pixel  <= '0;
      Output_Valid  <= 1'b0;
      Output_Finish <= 1'b0;
      Frame_Error   <= 1'b0;
    end else begin
      Output_Valid  <= 1'b0;
      Output_Finish <= 1'b0;
      Frame_Error   <= 1'b0;
      if (Input_Valid) begin
        if (state == S_IDLE) mode_q <= Pool_Mode;
        if (win_done) begin
          Output_Valid <= 1'b1;
          Output_Pixel <= result;
        end
        if (last_px) begin
          // Natural frame end; a missing Input_Finish is flagged but not fatal.
          Output_Finish <= 1'b1;
          Frame_Error   <= !Input_Finish;
          col           <= '0;
          row           <= '0;
          state         <= S_IDLE;
        end else if (Input_Finish) begin
          // Early finish aborts the frame after consuming this pixel.
          Output_Finish <= 1'b1;
          Frame_Error   <= 1'b1;
          col           <= '0;
          row           <= '0;
          state         <= S_IDLE;
        end else if (last_col) begin
          col   <= '0;
          row   <= row + 1'b1;
          state <= (state == S_BOT) ? S_TOP : S_BOT;
        end else begin
          col <= col + 1'b1;
          if (state == S_IDLE) state <= S_TOP;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_samp_pool2x2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_samp_pool2x2
//  Brief    : Directed self-checking bench for samp_pool2x2 on a 4x4 frame.
//  Revision : 1.0  initial release
// ============================================================================
module tb_samp_pool2x2;

  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              resetn;
  logic              soft_rst;
  logic [DATA_W-1:0] in_pixel;
  logic              in_valid;
  logic              in_finish;
  logic              pool_mode;
  logic [DATA_W-1:0] out_pixel;
  logic              out_valid;
  logic              out_finish;
  logic              frame_error;

  int passed = 0;
  int total  = 0;

  logic signed [DATA_W-1:0] px [16];
  logic signed [DATA_W-1:0] ex [4];

  samp_pool2x2 #(.DATA_W(DATA_W), .IMG_W(4), .IMG_H(4)) dut (
    .h_clk        (clk),
    .h_resetn     (resetn),
    .Input_Reset  (soft_rst),
    .Input_Pixel  (in_pixel),
    .Input_Valid  (in_valid),
    .Input_Finish (in_finish),
    .Pool_Mode    (pool_mode),
    .Output_Pixel (out_pixel),
    .Output_Valid (out_valid),
    .Output_Finish(out_finish),
    .Frame_Error  (frame_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else passed++;
  endtask

  task automatic load_frame_a();
    int fa [16] = '{1, 5, 2, 3, 4, -7, 8, 0, -1, -2, -3, -4, -5, -6, -7, -8};
    for (int i = 0; i < 16; i++) px[i] = 16'(fa[i]);
  endtask

  task automatic load_const(input logic [15:0] v);
    for (int i = 0; i < 16; i++) px[i] = v;
  endtask

  task automatic set_exp(input int a, input int b, input int c, input int d);
    ex[0] = 16'(a); ex[1] = 16'(b); ex[2] = 16'(c); ex[3] = 16'(d);
  endtask

  // Sends n pixels of px[]; fin_idx = pixel carrying Input_Finish (-1: none).
  // gap_mod > 0 inserts an idle cycle (with a stray Input_Finish) after pixels
  // whose index mod gap_mod is 1. Pool_Mode is inverted after pixel 0.
  task automatic run_frame(input logic mode, input int fin_idx, input int gap_mod,
                           input int n, input string tag);
    logic win, exp_fin, exp_err;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_pixel  = px[i];
      in_finish = (i == fin_idx);
      pool_mode = (i == 0) ? mode : ~mode;
      @(posedge clk); #1;
      win     = ((i / 4) % 2 == 1) && (i % 2 == 1);
      exp_fin = (i == 15) || (i == fin_idx);
      exp_err = exp_fin && !(i == 15 && fin_idx == 15);
      check($sformatf("%s_valid%0d", tag, i), 16'(out_valid), 16'(win));
      if (win) check($sformatf("%s_pix%0d", tag, i), out_pixel, ex[(i / 8) * 2 + (i % 4) / 2]);
      check($sformatf("%s_fin%0d", tag, i), 16'(out_finish), 16'(exp_fin));
      check($sformatf("%s_err%0d", tag, i), 16'(frame_error), 16'(exp_err));
      if (i == fin_idx && i != 15) break;
      if (gap_mod > 0 && (i % gap_mod) == 1 && i != 15) begin
        @(negedge clk);
        in_valid  = 1'b0;
        in_finish = 1'b1;
        @(posedge clk); #1;
        check($sformatf("%s_gapv%0d", tag, i), 16'(out_valid), 16'd0);
        check($sformatf("%s_gapf%0d", tag, i), 16'(out_finish), 16'd0);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      in_finish = 1'b0;
    end
  endtask

  initial begin
    resetn = 1'b0; soft_rst = 1'b0; in_pixel = '0; in_valid = 1'b0;
    in_finish = 1'b0; pool_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pix",   out_pixel, 16'd0);
    check("rst_valid", 16'(out_valid), 16'd0);
    check("rst_fin",   16'(out_finish), 16'd0);
    check("rst_err",   16'(frame_error), 16'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Max frame, then the same frame in average mode back-to-back with gaps.
    load_frame_a();
    set_exp(5, 8, -1, -3);
    run_frame(1'b0, 15, 0, 16, "max");
    set_exp(0, 3, -4, -6);
    run_frame(1'b1, 15, 3, 16, "avg_gap");

    // Saturation-range values.
    load_const(16'h7FFF);
    set_exp(32767, 32767, 32767, 32767);
    run_frame(1'b0, 15, 0, 16, "max7fff");
    load_const(16'h8000);
    set_exp(-32768, -32768, -32768, -32768);
    run_frame(1'b1, 15, 0, 16, "avg8000");

    // Abort on pixel 9, then a clean frame.
    load_frame_a();
    set_exp(5, 8, -1, -3);
    run_frame(1'b0, 9, 0, 16, "abort");
    run_frame(1'b0, 15, 0, 16, "post_abort");

    // Last pixel without Input_Finish.
    set_exp(0, 3, -4, -6);
    run_frame(1'b1, -1, 0, 16, "nofin");
    idle(2);

    // Hard reset mid-row, then back-to-back frames of opposite mode.
    set_exp(5, 8, -1, -3);
    run_frame(1'b0, -2, 0, 6, "partial");
    @(negedge clk);
    in_valid = 1'b0;
    resetn   = 1'b0;
    @(posedge clk); #1;
    check("hrst_pix",   out_pixel, 16'd0);
    check("hrst_valid", 16'(out_valid), 16'd0);
    resetn = 1'b1;
    set_exp(0, 3, -4, -6);
    run_frame(1'b1, 15, 0, 16, "b2b_avg");
    set_exp(5, 8, -1, -3);
    run_frame(1'b0, 15, 0, 16, "b2b_max");

    // Soft clear mid-frame, then an average frame from pixel 0.
    run_frame(1'b0, -2, 0, 3, "soft_part");
    @(negedge clk);
    in_valid = 1'b0;
    soft_rst = 1'b1;
    @(posedge clk); #1;
    check("srst_pix", out_pixel, 16'd0);
    soft_rst = 1'b0;
    set_exp(0, 3, -4, -6);
    run_frame(1'b1, 15, 2, 16, "post_srst");
    idle(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
